// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART definitions (FSM state encoding, frame geometry)
//               used by both the receiver and the transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

   localparam int unsigned UART_DATA_BITS = 8;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      START   = 3'd1,
      DATA    = 3'd2,
      STOP    = 3'd3,
      CLEANUP = 3'd4
   } uart_state_e;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Two-flop synchronizer for a single asynchronous input bit.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic i_Clock,
   input  logic i_Reset,
   input  logic i_D,
   output logic o_Q
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         r_meta <= RESET_VAL;
         r_sync <= RESET_VAL;
      end else begin
         r_meta <= i_D;
         r_sync <= r_meta;
      end
   end

   assign o_Q = r_sync;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : 8N1 UART receiver, mid-bit sampling, frame-error detection.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 87
) (
   input  logic       i_Clock,
   input  logic       i_Reset,
   input  logic       i_Rx_Serial,
   output logic       o_Rx_DV,
   output logic [7:0] o_Rx_Byte,
   output logic       o_Rx_Frame_Err,
   output logic       o_Rx_Active
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] c_MID_CNT  = CNT_W'((CLKS_PER_BIT - 1) / 2);
   localparam logic [CNT_W-1:0] c_LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

   logic             w_rx_sync;
   uart_state_e      r_state;
   logic [CNT_W-1:0] r_clk_cnt;
   logic [2:0]       r_bit_idx;
   logic [7:0]       r_shift;
   logic [7:0]       r_rx_byte;
   logic             r_rx_dv;
   logic             r_frame_err;
   logic             r_active;

   sync_2ff #(.RESET_VAL(1'b1)) u_sync (
      .i_Clock (i_Clock),
      .i_Reset (i_Reset),
      .i_D     (i_Rx_Serial),
      .o_Q     (w_rx_sync)
   );

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         r_state     <= IDLE;
         r_clk_cnt   <= '0;
         r_bit_idx   <= '0;
         r_shift     <= '0;
         r_rx_byte   <= '0;
         r_rx_dv     <= 1'b0;
         r_frame_err <= 1'b0;
         r_active    <= 1'b0;
      end else begin
         // Status outputs are single-cycle strobes unless re-armed below.
         r_rx_dv     <= 1'b0;
         r_frame_err <= 1'b0;
         case (r_state)
            IDLE: begin
               r_clk_cnt <= '0;
               r_bit_idx <= '0;
               if (!w_rx_sync) begin
                  r_state  <= START;
                  r_active <= 1'b1;
               end
            end
            START: begin
               if (r_clk_cnt == c_MID_CNT) begin
                  r_clk_cnt <= '0;
                  if (!w_rx_sync) begin
                     r_state <= DATA;
                  end else begin
                     r_state  <= IDLE;
                     r_active <= 1'b0;
                  end
               end else begin
                  r_clk_cnt <= r_clk_cnt + CNT_W'(1);
               end
            end
            DATA: begin
               if (r_clk_cnt == c_LAST_CNT) begin
                  r_clk_cnt          <= '0;
                  r_shift[r_bit_idx] <= w_rx_sync;
                  if (r_bit_idx == 3'd7) begin
                     r_bit_idx <= '0;
                     r_state   <= STOP;
                  end else begin
                     r_bit_idx <= r_bit_idx + 3'd1;
                  end
               end else begin
                  r_clk_cnt <= r_clk_cnt + CNT_W'(1);
               end
            end
            STOP: begin
               if (r_clk_cnt == c_LAST_CNT) begin
                  r_clk_cnt <= '0;
                  r_state   <= CLEANUP;
                  if (w_rx_sync) begin
                     r_rx_byte <= r_shift;
                     r_rx_dv   <= 1'b1;
                  end else begin
                     r_frame_err <= 1'b1;
                  end
               end else begin
                  r_clk_cnt <= r_clk_cnt + CNT_W'(1);
               end
            end
            CLEANUP: begin
               r_state  <= IDLE;
               r_active <= 1'b0;
            end
            default: begin
               r_state  <= IDLE;
               r_active <= 1'b0;
            end
         endcase
      end
   end

   assign o_Rx_DV        = r_rx_dv;
   assign o_Rx_Byte      = r_rx_byte;
   assign o_Rx_Frame_Err = r_frame_err;
   assign o_Rx_Active    = r_active;

endmodule : uart_rx
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx
// Description : Self-checking bench for uart_rx (CLKS_PER_BIT = 4 and 87).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

   logic       i_Clock = 1'b0;
   logic       i_Reset = 1'b1;
   logic       rx4     = 1'b1;
   logic       rx87    = 1'b1;
   logic       dv4, fe4, act4, dv87, fe87, act87;
   logic [7:0] byte4, byte87;

   uart_rx #(.CLKS_PER_BIT(4)) u_dut4 (
      .i_Clock        (i_Clock),
      .i_Reset        (i_Reset),
      .i_Rx_Serial    (rx4),
      .o_Rx_DV        (dv4),
      .o_Rx_Byte      (byte4),
      .o_Rx_Frame_Err (fe4),
      .o_Rx_Active    (act4)
   );

   uart_rx #(.CLKS_PER_BIT(87)) u_dut87 (
      .i_Clock        (i_Clock),
      .i_Reset        (i_Reset),
      .i_Rx_Serial    (rx87),
      .o_Rx_DV        (dv87),
      .o_Rx_Byte      (byte87),
      .o_Rx_Frame_Err (fe87),
      .o_Rx_Active    (act87)
   );

   always #5 i_Clock = ~i_Clock;

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic check_rng(input string name, input int act, input int lo, input int hi);
      tests++;
      if (act < lo || act > hi) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   // Monitor on the fast receiver: pulse counts, received bytes, invariants.
   int         dv_cnt   = 0;
   int         fe_cnt   = 0;
   int         viol_cnt = 0;
   logic [7:0] rxq[$];
   logic [7:0] prev_byte;
   logic       prev_dv  = 1'b0;
   logic       prev_fe  = 1'b0;
   logic       rst_q;

   always @(posedge i_Clock) rst_q <= i_Reset;

   always @(negedge i_Clock) begin
      if (dv4) begin
         dv_cnt++;
         rxq.push_back(byte4);
      end
      if (fe4) fe_cnt++;
      if (dv4 && fe4) viol_cnt++;
      if ((dv4 && prev_dv) || (fe4 && prev_fe)) viol_cnt++;
      if (byte4 !== prev_byte && !dv4 && !rst_q) viol_cnt++;
      prev_byte = byte4;
      prev_dv   = dv4;
      prev_fe   = fe4;
   end

   task automatic idle(input int n);
      repeat (n) @(posedge i_Clock);
      #1;
   endtask

   task automatic drive(input bit sel, input logic v);
      int n = sel ? 87 : 4;
      if (sel) rx87 = v;
      else     rx4  = v;
      idle(n);
   endtask

   task automatic send(input bit sel, input logic [7:0] b, input logic stop_v);
      drive(sel, 1'b0);
      for (int i = 0; i < 8; i++) drive(sel, b[i]);
      drive(sel, stop_v);
   endtask

   typedef struct {
      logic [7:0] data;
      logic       stop;
      int         dv;
      int         fe;
      logic [7:0] exp_byte;
   } vec_t;

   vec_t       vecs[5];
   logic [7:0] b2b[3];
   int         d0, f0, base, run, maxrun, n;
   logic       got;

   initial begin
      vecs[0] = '{8'hA5, 1'b1, 1, 0, 8'hA5};
      vecs[1] = '{8'h3C, 1'b0, 0, 1, 8'hA5};
      vecs[2] = '{8'hC3, 1'b1, 1, 0, 8'hC3};
      vecs[3] = '{8'h01, 1'b0, 0, 1, 8'hC3};
      vecs[4] = '{8'h80, 1'b1, 1, 0, 8'h80};
      b2b[0]  = 8'h00;
      b2b[1]  = 8'hFF;
      b2b[2]  = 8'h55;

      // Reset state
      idle(3);
      @(negedge i_Clock);
      check("reset dv", dv4, 0);
      check("reset ferr", fe4, 0);
      check("reset active", act4, 0);
      check("reset byte", byte4, 8'h00);
      check("reset byte87", byte87, 8'h00);
      @(posedge i_Clock);
      #1;
      i_Reset = 1'b0;
      idle(4);

      // Isolated frames, good and bad stop bit
      for (int i = 0; i < 5; i++) begin
         d0 = dv_cnt;
         f0 = fe_cnt;
         send(1'b0, vecs[i].data, vecs[i].stop);
         rx4 = 1'b1;
         idle(8);
         check($sformatf("vec%0d dv", i), dv_cnt - d0, vecs[i].dv);
         check($sformatf("vec%0d ferr", i), fe_cnt - f0, vecs[i].fe);
         check($sformatf("vec%0d byte", i), byte4, vecs[i].exp_byte);
         check($sformatf("vec%0d active", i), act4, 0);
      end

      // One-cycle glitch on an idle line
      d0 = dv_cnt;
      f0 = fe_cnt;
      rx4 = 1'b0;
      idle(1);
      rx4 = 1'b1;
      run = 0;
      maxrun = 0;
      repeat (20) begin
         @(negedge i_Clock);
         run = act4 ? run + 1 : 0;
         if (run > maxrun) maxrun = run;
      end
      @(posedge i_Clock);
      #1;
      check("glitch dv", dv_cnt - d0, 0);
      check("glitch ferr", fe_cnt - f0, 0);
      check_rng("glitch active cycles", maxrun, 1, 3);

      // Back-to-back frames
      base = rxq.size();
      for (int i = 0; i < 3; i++) send(1'b0, b2b[i], 1'b1);
      idle(10);
      check("b2b count", rxq.size() - base, 3);
      for (int i = 0; i < 3; i++)
         check($sformatf("b2b byte%0d", i),
               (rxq.size() > base + i) ? {24'd0, rxq[base + i]} : 32'hDEAD, b2b[i]);

      // Break: line held low restarts frames, each one a framing error
      d0 = dv_cnt;
      f0 = fe_cnt;
      rx4 = 1'b0;
      idle(130);
      check("break ferr", fe_cnt - f0, 3);
      check("break dv", dv_cnt - d0, 0);
      rx4 = 1'b1;
      idle(60);

      // Reset during data bit 4 of 8'h81, then a clean 8'h42
      d0 = dv_cnt;
      f0 = fe_cnt;
      drive(1'b0, 1'b0);
      drive(1'b0, 1'b1);
      drive(1'b0, 1'b0);
      drive(1'b0, 1'b0);
      drive(1'b0, 1'b0);
      rx4 = 1'b0;
      idle(2);
      check("mid-frame active", act4, 1);
      i_Reset = 1'b1;
      rx4 = 1'b1;
      idle(1);
      i_Reset = 1'b0;
      check("rst dv", dv4, 0);
      check("rst ferr", fe4, 0);
      check("rst active", act4, 0);
      check("rst byte", byte4, 8'h00);
      idle(40);
      check("abandoned dv", dv_cnt - d0, 0);
      check("abandoned ferr", fe_cnt - f0, 0);
      d0 = dv_cnt;
      send(1'b0, 8'h42, 1'b1);
      idle(8);
      check("after rst dv", dv_cnt - d0, 1);
      check("after rst byte", byte4, 8'h42);

      // Latency at CLKS_PER_BIT = 87
      n = 0;
      got = 1'b0;
      fork
         send(1'b1, 8'h7E, 1'b1);
         begin
            for (int k = 0; k < 1200 && !got; k++) begin
               @(negedge i_Clock);
               n++;
               if (dv87) got = 1'b1;
            end
         end
      join
      check("cbp87 dv seen", got, 1);
      check("cbp87 byte", byte87, 8'h7E);
      check_rng("cbp87 latency", n - 1, 828, 830);

      check("pulse/byte invariants", viol_cnt, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, %0d tests run", tests);
      $fatal(1, "timeout");
   end

endmodule : tb_uart_rx
`default_nettype wire
